// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the event FIFO.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address 0..depth-1, never narrower than one bit.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Accepted writes land at the write pointer on the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO for spike/event words with FWFT or registered read,
// occupancy count, threshold flags and sticky error flags.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FWFT      = FIFO_MODE_FWFT,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Reject illegal configurations at elaboration time.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_fwft: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_fwft: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] rd_data;

  // Pointers wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Flags come straight from the registered count.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // Next-state for pointers, occupancy and sticky errors (set beats clear).
  always_comb begin
    wr_ptr_d    = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !wr_acc) overflow_d  = 1'b1;
    if (rd_en && !rd_acc) underflow_d = 1'b1;
  end

  // Control state registers; reset discards every stored entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented directly; zero when nothing is stored.
    assign dout       = empty ? '0 : rd_data;
    assign dout_valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    // Capture the head on an accepted read; valid is a one-cycle pulse.
    always_comb begin
      dout_d       = rd_acc ? rd_data : dout_q;
      dout_valid_d = rd_acc;
    end

    // Registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_q       <= dout_d;
        dout_valid_q <= dout_valid_d;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench: four FIFO configurations run side by side, each with a
// queue-based reference model, a scoreboard of expected read words and a
// monitor that pops and compares whenever its DUT delivers a word.
module tb_sync_fifo_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int cfg, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: actual=0x%0h required=0x%0h", cfg, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int DEPTH = (gi == 0) ? 5 : (gi == 1) ? 7 : 8;
    localparam int FWFT  = (gi == 0 || gi == 2) ? 1 : 0;
    localparam int AF    = (gi == 0) ? 3 : (gi == 1) ? 5 : (gi == 2) ? 6 : 7;
    localparam int AE    = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 2 : 0;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          rst_n, wr_en, rd_en, clr_err;
    logic [7:0]    din, dout;
    logic          dout_valid, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [CW-1:0] count;

    sync_fifo_fwft #(
      .WIDTH     (8),
      .DEPTH     (DEPTH),
      .FWFT      (FWFT),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
    );

    // Reference model: contents as a plain queue plus error and output state.
    logic [7:0] mq [$];
    logic [7:0] sb [$];
    bit         m_ovf, m_udf, m_dv;
    logic [7:0] m_dout;
    int         txn = 0;

    task automatic model_reset();
      mq.delete();
      sb.delete();
      m_ovf  = 0;
      m_udf  = 0;
      m_dv   = 0;
      m_dout = 8'h00;
    endtask

    task automatic check_state(input string tag);
      int         sz;
      logic [7:0] exp_dout;
      sz = mq.size();
      exp_dout = (FWFT == 1) ? ((sz > 0) ? mq[0] : 8'h00) : m_dout;
      chk({tag, "/count"}, gi, int'(count), sz);
      chk({tag, "/full"}, gi, int'(full), int'(sz == DEPTH));
      chk({tag, "/empty"}, gi, int'(empty), int'(sz == 0));
      chk({tag, "/almost_full"}, gi, int'(almost_full), int'(sz >= AF));
      chk({tag, "/almost_empty"}, gi, int'(almost_empty), int'(sz <= AE));
      chk({tag, "/overflow"}, gi, int'(overflow), int'(m_ovf));
      chk({tag, "/underflow"}, gi, int'(underflow), int'(m_udf));
      chk({tag, "/dout_valid"}, gi, int'(dout_valid), (FWFT == 1) ? int'(sz > 0) : int'(m_dv));
      chk({tag, "/dout"}, gi, int'(dout), int'(exp_dout));
    endtask

    // Drive one cycle of inputs (called #1 after a rising edge), advance the
    // model across the next edge and compare the settled DUT state.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d, input bit c,
                         input string tag);
      bit         ra, wa;
      logic [7:0] h;
      wr_en   = w;
      rd_en   = r;
      din     = d;
      clr_err = c;
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < DEPTH) || ra);
      m_dv = ra;
      if (ra) begin
        h = mq.pop_front();
        sb.push_back(h);
        m_dout = h;
      end
      if (wa) mq.push_back(d);
      if (w && !wa) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (r && !ra) m_udf = 1;
      else if (c) m_udf = 0;
      @(posedge clk);
      #1;
      check_state(tag);
    endtask

    // Monitor: a word is delivered on a FWFT pop or a registered-read pulse.
    always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n && ((FWFT == 1) ? (rd_en && dout_valid) : dout_valid)) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_word", gi, sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("sb_data", gi, int'(dout), int'(e));
          txn++;
          $display("cfg%0d rd #%0d data=0x%02h expected=0x%02h", gi, txn, dout, e);
        end
      end
    end

    initial begin
      int pw, pr;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      din     = 8'h00;
      clr_err = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_state("reset");
      #2 rst_n = 1'b1;

      // Fill to full, then one write too many.
      for (int i = 0; i < DEPTH; i++) begin
        cycle(1, 0, 8'h11 + 8'(i), 0, "fill");
        chk("fill_count_explicit", gi, int'(count), i + 1);
      end
      chk("full_explicit", gi, int'(full), 1);
      chk("head_explicit", gi, int'(dout), (FWFT == 1) ? 8'h11 : 8'h00);
      cycle(1, 0, 8'hEE, 0, "overfill");
      chk("overflow_explicit", gi, int'(overflow), 1);
      chk("overfill_count_explicit", gi, int'(count), DEPTH);

      // Clear, then simultaneous read+write on a full FIFO, then drain across the wrap.
      cycle(0, 0, 8'h00, 1, "clr_ovf");
      cycle(1, 1, 8'h66, 0, "full_rw");
      chk("full_rw_count_explicit", gi, int'(count), DEPTH);
      chk("full_rw_ovf_explicit", gi, int'(overflow), 0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0, "drain");
      cycle(0, 0, 8'h00, 0, "idle");
      chk("drained_empty_explicit", gi, int'(empty), 1);

      // Single word through, then idle: registered mode holds dout after the pulse.
      cycle(1, 0, 8'hA5, 0, "wr_a5");
      cycle(0, 1, 8'h00, 0, "rd_a5");
      cycle(0, 0, 8'h00, 0, "hold_a5");
      chk("hold_dout_explicit", gi, int'(dout), (FWFT == 1) ? 8'h00 : 8'hA5);
      chk("hold_valid_explicit", gi, int'(dout_valid), 0);

      // Empty FIFO with read and write together; clear versus fresh underflow.
      cycle(1, 1, 8'h3C, 0, "empty_rw");
      chk("empty_rw_udf_explicit", gi, int'(underflow), 1);
      chk("empty_rw_count_explicit", gi, int'(count), 1);
      cycle(0, 0, 8'h00, 1, "clr_udf");
      chk("clr_udf_explicit", gi, int'(underflow), 0);
      cycle(0, 1, 8'h00, 0, "rd_3c");
      cycle(0, 1, 8'h00, 1, "set_beats_clr");
      chk("set_beats_clr_explicit", gi, int'(underflow), 1);
      cycle(0, 0, 8'h00, 1, "clr_again");

      // Asynchronous reset between edges with data stored.
      for (int i = 0; i < 3; i++) cycle(1, 0, 8'hC0 + 8'(i), 0, "pre_rst");
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_state("async_rst");
      chk("async_rst_count_explicit", gi, int'(count), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cycle(0, 1, 8'h00, 0, "rd_after_rst");
      chk("rd_after_rst_udf_explicit", gi, int'(underflow), 1);
      cycle(0, 0, 8'h00, 1, "clr_after_rst");

      // Randomised traffic with alternating fill-biased and drain-biased phases.
      for (int k = 0; k < 10000; k++) begin
        pw = ((k / 150) % 2 == 0) ? 70 : 30;
        pr = 100 - pw;
        cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
              8'($urandom), $urandom_range(0, 99) < 3, "rand");
      end
      cycle(0, 0, 8'h00, 0, "final");
      chk("sb_leftover", gi, sb.size(), 0);
      done_cnt++;
    end
  end

  initial begin
    for (int k = 0; k < 30000 && done_cnt < 4; k++) @(posedge clk);
    chk("all_configs_done", -1, done_cnt, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Parametrised single-clock FIFO. It buffers spike/event words between producer and consumer stages of the core.
- Supports any DEPTH (not only powers of two).
- Selectable read mode: first-word-fall-through (FWFT) or registered standard read.
- Provides an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, any integer)
FWFT, 1, 1 = head word visible on dout while non-empty; 0 = dout registered, updated one cycle after an accepted read
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request (FWFT: acknowledge/pop of current head)
clr_err  in  1  clears overflow/underflow
dout  out  WIDTH  read data
dout_valid  out  1  dout holds valid data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  CW  occupancy, CW = $clog2(DEPTH+1)
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected

Behaviour:
- Reset (rst_n low, async): wr_ptr, rd_ptr, count = 0; overflow = underflow = 0; registered dout = 0; dout_valid = 0. Memory contents are not cleared. Resetting mid-transfer discards all entries; the first cycle after release behaves as empty.
- Pointers run 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. There is no power-of-two masking. Full/empty are derived from count, not from pointer comparison.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO succeeds when a read is accepted in the same cycle.
- Empty FIFO with wr_en and rd_en both high: the write is accepted and the read is rejected (underflow sets). In FWFT mode the new word appears on dout the following cycle.
- count_next = count + wr_acc - rd_acc. Use CW-bit arithmetic; it never exceeds DEPTH.
- Flags full, empty, almost_full, almost_empty are combinational from the registered count. They are glitch-free relative to clk.
- FWFT=1:
  - dout = mem[rd_ptr] when !empty, else 0.
  - dout_valid = !empty.
  - Latency from write to dout = 1 cycle.
  - A read pops the head at the clock edge; the next word is visible the same cycle the pop is registered.
- FWFT=0:
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 in the next cycle.
  - Otherwise dout holds its last value and dout_valid <= 0 (one-cycle pulse per accepted read).
  - Read latency = 1 cycle.
- overflow sets on wr_en && !wr_acc. underflow sets on rd_en && !rd_acc.
- Both error flags stay set until a clr_err cycle. If set and clr_err occur in the same cycle, set wins.
- Rejected operations do not alter pointers, count, or memory.
- Write data lands in mem[wr_ptr] at the clock edge of wr_acc.
- Parameter checks (elaboration assertions): DEPTH >= 2; 1 <= AF_THRESH <= DEPTH; AE_THRESH < DEPTH.

Decomposition:
- Shared package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1)
  - function ptr_w(depth) returning max(1, $clog2(depth))
  - the read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
- One sub-module, fifo_mem: WIDTH x DEPTH array, one synchronous write port, one asynchronous read port, no reset.
- The top level holds pointers, count, flags, the error logic, and the FWFT/standard output stage (generate on FWFT).

Test Plan:
1. DEPTH=5, FWFT=1: write 0x11..0x15 back-to-back -> count 1..5, full after 5th write, almost_full at count 3, dout=0x11 one cycle after first write; 6th write -> overflow=1, count stays 5.
2. DEPTH=5 full: wr_en and rd_en in the same cycle with din=0x66 -> both accepted, count stays 5, overflow stays 0; drain all -> order 0x12,0x13,0x14,0x15,0x66, pointer wrap crossed.
3. FWFT=0: write 0xA5, then pulse rd_en -> dout=0xA5 and dout_valid=1 exactly one cycle later, then dout_valid=0 while dout holds 0xA5.
4. Empty FIFO, wr_en+rd_en together, din=0x3C -> count=1, underflow=1; next cycle dout=0x3C (FWFT); clr_err -> underflow=0; clr_err together with a new rd_en on empty -> underflow stays 1.
5. Write 3 words, assert rst_n low between clock edges -> outputs clear immediately (count=0, empty=1, dout_valid=0, errors 0); after release, a read gives underflow and no stale data.
6. Random wr/rd (10k cycles), DEPTH=7 and DEPTH=8, both modes -> scoreboard data order exact, count matches model, flags match thresholds every cycle.
